// File: rtl/btn_debounce.sv
// Per-button synchronizer, debouncer and press/release pulse generator.
// Optional auto-repeat of the press pulse under macro BTN_AUTOREPEAT_EN.
module btn_debounce #(
    parameter int unsigned NB_BTN       = 4,
    parameter int unsigned NB_CNT       = 20,
    parameter int unsigned N_STABLE     = 1000000,
    parameter int unsigned N_REP_DELAY  = 50000000,
    parameter int unsigned N_REP_PERIOD = 10000000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_STABLE - 1);

    // Reject parameter sets the counters cannot represent.
    if (N_STABLE < 1 || N_REP_DELAY < 1 || N_REP_PERIOD < 1 ||
        64'(N_STABLE) >= (64'd1 << NB_CNT)) begin : g_bad_param
        $error("btn_debounce: illegal parameter value");
    end

    logic [NB_BTN-1:0] r_sync1;
    logic [NB_BTN-1:0] r_sync2;
    state_t            r_state [NB_BTN];
    logic [NB_CNT-1:0] r_cnt   [NB_BTN];
    logic [NB_BTN-1:0] r_level;
    logic [NB_BTN-1:0] r_press;
    logic [NB_BTN-1:0] r_release;

    state_t            w_state [NB_BTN];
    logic [NB_CNT-1:0] w_cnt   [NB_BTN];
    logic [NB_BTN-1:0] w_level;
    logic [NB_BTN-1:0] w_press;
    logic [NB_BTN-1:0] w_release;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned NB_REP = $clog2((N_REP_DELAY > N_REP_PERIOD) ?
                                            N_REP_DELAY : N_REP_PERIOD) + 1;
    localparam logic [NB_REP-1:0] REP_ONE        = NB_REP'(1);
    localparam logic [NB_REP-1:0] REP_DELAY_LAST = NB_REP'(N_REP_DELAY - 1);
    localparam logic [NB_REP-1:0] REP_PER_LAST   = NB_REP'(N_REP_PERIOD - 1);

    logic [NB_REP-1:0] r_rep    [NB_BTN];
    logic [NB_BTN-1:0] r_rep_ph;
    logic [NB_REP-1:0] w_rep    [NB_BTN];
    logic [NB_BTN-1:0] w_rep_ph;
`endif

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < int'(NB_BTN); i++) begin
                r_state[i] <= STABLE_LOW;
                r_cnt[i]   <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            r_rep_ph <= '0;
            for (int i = 0; i < int'(NB_BTN); i++) r_rep[i] <= '0;
`endif
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
            for (int i = 0; i < int'(NB_BTN); i++) begin
                r_state[i] <= w_state[i];
                r_cnt[i]   <= w_cnt[i];
            end
`ifdef BTN_AUTOREPEAT_EN
            r_rep_ph <= w_rep_ph;
            for (int i = 0; i < int'(NB_BTN); i++) r_rep[i] <= w_rep[i];
`endif
        end
    end

    // Next-state and output decode, one independent FSM per channel.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_level   = r_level;
        w_press   = '0;
        w_release = '0;
`ifdef BTN_AUTOREPEAT_EN
        w_rep    = r_rep;
        w_rep_ph = r_rep_ph;
`endif
        for (int i = 0; i < int'(NB_BTN); i++) begin
            case (r_state[i])
                STABLE_LOW: begin
                    if (r_sync2[i]) begin
                        w_state[i] = WAIT_HIGH;
                        w_cnt[i]   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!r_sync2[i]) begin
                        w_state[i] = STABLE_LOW;
                        w_cnt[i]   = '0;
                    end else if (r_cnt[i] >= CNT_LAST) begin
                        w_state[i] = STABLE_HIGH;
                        w_cnt[i]   = '0;
                        w_level[i] = 1'b1;
                        w_press[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_rep[i]    = '0;
                        w_rep_ph[i] = 1'b0;
`endif
                    end else begin
                        w_cnt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!r_sync2[i]) begin
                        w_state[i] = WAIT_LOW;
                        w_cnt[i]   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                        w_rep[i]    = '0;
                        w_rep_ph[i] = 1'b0;
`endif
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // First repeat after the delay, then one per period.
                    else if (r_rep[i] == (r_rep_ph[i] ? REP_PER_LAST : REP_DELAY_LAST)) begin
                        w_press[i]  = 1'b1;
                        w_rep[i]    = '0;
                        w_rep_ph[i] = 1'b1;
                    end else begin
                        w_rep[i] = r_rep[i] + REP_ONE;
                    end
`endif
                end
                WAIT_LOW: begin
                    if (r_sync2[i]) begin
                        w_state[i] = STABLE_HIGH;
                        w_cnt[i]   = '0;
                    end else if (r_cnt[i] >= CNT_LAST) begin
                        w_state[i]   = STABLE_LOW;
                        w_cnt[i]     = '0;
                        w_level[i]   = 1'b0;
                        w_release[i] = 1'b1;
                    end else begin
                        w_cnt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    w_state[i] = STABLE_LOW;
                    w_cnt[i]   = '0;
                end
            endcase
        end
    end

    assign o_btn_level   = r_level;
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (N_STABLE=4, NB_CNT=4).
module tb_btn_debounce;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_btn;
    logic [3:0] o_btn_level;
    logic [3:0] o_btn_press;
    logic [3:0] o_btn_release;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .NB_BTN      (4),
        .NB_CNT      (4),
        .N_STABLE    (4),
        .N_REP_DELAY (20),
        .N_REP_PERIOD(8)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_btn        (i_btn),
        .o_btn_level  (o_btn_level),
        .o_btn_press  (o_btn_press),
        .o_btn_release(o_btn_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_btn   = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({o_btn_level, o_btn_press, o_btn_release} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold k=%0d got lvl=%b prs=%b rel=%b want all 0",
                         k, o_btn_level, o_btn_press, o_btn_release);
            end
        end
        i_reset = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            logic [3:0] el, ep;
            tick();
            el = (k >= 5) ? 4'hF : 4'h0;
            ep = (k == 5) ? 4'hF : 4'h0;
            checks++;
            if (o_btn_level !== el || o_btn_press !== ep || o_btn_release !== 4'h0) begin
                errors++;
                $display("FAIL reset_release edge=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0000",
                         k, o_btn_level, o_btn_press, o_btn_release, el, ep);
            end
        end
    endtask

    task automatic test_release_all();
        i_btn = 4'h0;
        for (int k = 0; k <= 6; k++) begin
            logic [3:0] el, er;
            tick();
            el = (k >= 5) ? 4'h0 : 4'hF;
            er = (k == 5) ? 4'hF : 4'h0;
            checks++;
            if (o_btn_level !== el || o_btn_release !== er || o_btn_press !== 4'h0) begin
                errors++;
                $display("FAIL release_all edge=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=0000 rel=%b",
                         k, o_btn_level, o_btn_press, o_btn_release, el, er);
            end
        end
    endtask

    task automatic test_clean_press();
        i_btn[0] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            logic [3:0] el, ep;
            tick();
            el = (k >= 5) ? 4'b0001 : 4'b0000;
            ep = (k == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (o_btn_level !== el || o_btn_press !== ep || o_btn_release !== 4'h0) begin
                errors++;
                $display("FAIL clean_press edge=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0000",
                         k, o_btn_level, o_btn_press, o_btn_release, el, ep);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int j = 0; j < 6; j++) begin
            i_btn[1] = pat[j];
            tick();
            checks++;
            if (o_btn_level !== 4'b0001 || o_btn_press !== 4'h0 || o_btn_release !== 4'h0) begin
                errors++;
                $display("FAIL bounce_phase edge=%0d got lvl=%b prs=%b rel=%b want lvl=0001 prs=0000 rel=0000",
                         j, o_btn_level, o_btn_press, o_btn_release);
            end
        end
        i_btn[1] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            logic [3:0] el, ep;
            tick();
            el = (k >= 5) ? 4'b0011 : 4'b0001;
            ep = (k == 5) ? 4'b0010 : 4'b0000;
            checks++;
            if (o_btn_level !== el || o_btn_press !== ep || o_btn_release !== 4'h0) begin
                errors++;
                $display("FAIL bounce_settle edge=+%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0000",
                         k, o_btn_level, o_btn_press, o_btn_release, el, ep);
            end
        end
    endtask

    task automatic test_simultaneous();
        i_btn[3] = 1'b1;
        repeat (7) tick();
        checks++;
        if (o_btn_level !== 4'b1011) begin
            errors++;
            $display("FAIL simul_setup got lvl=%b want 1011", o_btn_level);
        end
        i_btn[2] = 1'b1;
        i_btn[3] = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            logic [3:0] el, ep, er;
            tick();
            el = (k >= 5) ? 4'b0111 : 4'b1011;
            ep = (k == 5) ? 4'b0100 : 4'b0000;
            er = (k == 5) ? 4'b1000 : 4'b0000;
            checks++;
            if (o_btn_level !== el || o_btn_press !== ep || o_btn_release !== er) begin
                errors++;
                $display("FAIL simultaneous edge=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                         k, o_btn_level, o_btn_press, o_btn_release, el, ep, er);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        i_btn = 4'h0;
        repeat (8) tick();
        checks++;
        if (o_btn_level !== 4'h0) begin
            errors++;
            $display("FAIL midrst_setup got lvl=%b want 0000", o_btn_level);
        end
        i_btn[0] = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (o_btn_press !== 4'h0 || o_btn_level !== 4'h0) begin
                errors++;
                $display("FAIL midrst_pre got lvl=%b prs=%b want 0000 0000", o_btn_level, o_btn_press);
            end
        end
        i_reset = 1'b0;
        tick();
        checks++;
        if ({o_btn_level, o_btn_press, o_btn_release} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_in_reset got lvl=%b prs=%b rel=%b want all 0",
                     o_btn_level, o_btn_press, o_btn_release);
        end
        i_reset = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            logic [3:0] el, ep;
            tick();
            el = (k >= 5) ? 4'b0001 : 4'b0000;
            ep = (k == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (o_btn_level !== el || o_btn_press !== ep || o_btn_release !== 4'h0) begin
                errors++;
                $display("FAIL midrst_after edge=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0000",
                         k, o_btn_level, o_btn_press, o_btn_release, el, ep);
            end
        end
    endtask

    task automatic test_autorepeat();
        i_btn = 4'h0;
        repeat (8) tick();
        i_btn[0] = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            logic ep, el;
            tick();
            ep = (t == 6);
`ifdef BTN_AUTOREPEAT_EN
            ep = ep || (t == 26) || (t == 34) || (t == 42) || (t == 50) || (t == 58);
`endif
            el = (t >= 6);
            checks++;
            if (o_btn_press !== {3'b000, ep} || o_btn_level !== {3'b000, el} ||
                o_btn_release !== 4'h0) begin
                errors++;
                $display("FAIL hold_repeat tick=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0000",
                         t, o_btn_level, o_btn_press, o_btn_release, {3'b000, el}, {3'b000, ep});
            end
        end
        i_btn[0] = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            logic er;
            tick();
            er = (t == 6);
            checks++;
            if (o_btn_release !== {3'b000, er} || o_btn_press !== 4'h0) begin
                errors++;
                $display("FAIL hold_release tick=%0d got prs=%b rel=%b want prs=0000 rel=%b",
                         t, o_btn_press, o_btn_release, {3'b000, er});
            end
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_btn   = 4'h0;
        test_reset();
        test_release_all();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the LED-sequencer top level. Runs on the same clock.
- Takes the NB_BTN raw, asynchronous push-button inputs and does three things per button:
  - synchronizes each input;
  - debounces each input independently;
  - produces a clean level plus single-cycle press/release pulses.
- The top level's mode-cycling and colour-select logic consume o_btn_level / o_btn_press instead of the raw pins, so bounce cannot skip modes.

Parameters:
- NB_BTN, 4, number of independent button channels.
- NB_CNT, 20, width of each per-channel stability counter.
- N_STABLE, 1000000, consecutive agreeing samples required to accept a new level (10 ms at 100 MHz). Legal range 1 to 2^NB_CNT-1.
- N_REP_DELAY, 50000000, cycles the level must stay high before auto-repeat starts. Used only with BTN_AUTOREPEAT_EN.
- N_REP_PERIOD, 10000000, cycles between auto-repeat pulses. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clock  in  1  system clock; all logic on posedge.
- i_reset  in  1  reset, synchronous, active-low.
- i_btn  in  NB_BTN  raw asynchronous button inputs, active-high.
- o_btn_level  out  NB_BTN  debounced level per button.
- o_btn_press  out  NB_BTN  one-cycle pulse on each accepted 0->1 level change.
- o_btn_release  out  NB_BTN  one-cycle pulse on each accepted 1->0 level change.

Behaviour:
- Interface: reset i_reset, synchronous, active-low; clock clock. On any edge with i_reset=0:
  - synchronizer flops, counters, FSMs -> 0/STABLE_LOW;
  - o_btn_level=0, o_btn_press=0, o_btn_release=0.
- Synchronizer: 2 flops per bit (sync1, sync2). An i_btn value sampled at edge 0 appears on sync2 after edge 1.
- Per-channel FSM, all channels fully independent (simultaneous activity on several buttons needs no arbitration). States:
  - STABLE_LOW: sync2=1 -> WAIT_HIGH, counter=1.
  - WAIT_HIGH:
    - sync2=0 -> STABLE_LOW, counter=0 (glitch rejected, no pulse);
    - else if counter==N_STABLE-1 -> STABLE_HIGH, level<=1, press pulse, counter=0;
    - else counter+1.
  - STABLE_HIGH: sync2=0 -> WAIT_LOW, counter=1.
  - WAIT_LOW: mirror of WAIT_HIGH; on commit -> STABLE_LOW, level<=0, release pulse.
- N_STABLE=1: the WAIT state commits on its first evaluation, i.e. the edge after entry.
- Latency: for input stable from edge 0, the WAIT state is entered at edge 2. o_btn_level and the corresponding pulse become valid after edge N_STABLE+1.
- Glitch rule: any single sync2 sample equal to the current level during WAIT_* aborts the change and restarts counting from zero on the next differing sample.
- Outputs are registered; no combinational path from i_btn.
- Pulse rules:
  - press and release are exactly 1 cycle wide;
  - press and release are never both high on the same channel in the same cycle;
  - the pulse cycle coincides with the level change.
- Counter never wraps: bounded by N_STABLE-1 < 2^NB_CNT.
- Reset mid-debounce: the partial count is discarded.
- Button held through reset release: treated as a new press. Level rises and press pulses after edge N_STABLE+1 counted from the first post-reset sampling edge.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined:
  - each channel has an extra repeat counter, active only in STABLE_HIGH;
  - after the level has been high for N_REP_DELAY cycles, o_btn_press pulses again, then every N_REP_PERIOD cycles while still high;
  - leaving STABLE_HIGH (entering WAIT_LOW) clears the repeat counter immediately;
  - o_btn_release is unaffected.
- Undefined:
  - no repeat logic is synthesized;
  - exactly one press pulse per accepted press;
  - the N_REP_* parameters are ignored.

Test Plan:
- Bench parameters: N_STABLE=4, NB_CNT=4, N_REP_DELAY=20, N_REP_PERIOD=8.
- Reset: i_reset=0 for 3 cycles with i_btn=4'b1111 -> all outputs 0 throughout. After release, o_btn_level=4'b1111 and o_btn_press=4'b1111 for one cycle, after edge 5 post-release.
- Clean press: i_btn[0] 0->1 sampled at edge 0, held -> o_btn_level[0]=1 and o_btn_press[0]=1 after edge 5. press=0 after edge 6; no further pulses.
- Bounce: i_btn[1] pattern 1,1,0,1,1,0 then steady 1 -> no output change during bouncing. Level and press assert exactly N_STABLE+1=5 edges after the last 0->1 transition.
- Simultaneous: i_btn[2] rises while i_btn[3] falls (was debounced high), same edge -> press[2] and release[3] both pulse in the same cycle; other channels are untouched.
- Reset mid-count: i_btn[0] high 2 cycles, then i_reset=0 for 1 cycle, input still high -> no pulse before reset. Press occurs 5 edges after reset release.
- BTN_AUTOREPEAT_EN defined: hold i_btn[0] high 60 cycles -> initial press, then a repeat at +20 cycles, then every 8 cycles (+28, +36, +44, +52). Release stops repeats; release pulses once.
